// File: rtl/sram_stream_reader_if.sv
// Handshake and bus bundle between the SRAM stream reader, its SRAM read port and the downstream consumer.
// Latency: none, wires only.
// Backpressure: out_ready from the consumer side throttles out_valid on the reader side.
interface sram_stream_reader_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16
);
  logic                  start;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [ADDR_WIDTH:0]   length;
  logic                  busy;
  logic                  done;
  logic [ADDR_WIDTH-1:0] sram_read_addr;
  logic [DATA_WIDTH-1:0] sram_read_data;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_last;

  // Reader side: consumes commands and SRAM data, produces addresses and the stream.
  modport master (
    input  start, base_addr, length, sram_read_data, out_ready,
    output busy, done, sram_read_addr, out_data, out_valid, out_last
  );

  // Environment side: command source, SRAM and stream consumer.
  modport slave (
    output start, base_addr, length, sram_read_data, out_ready,
    input  busy, done, sram_read_addr, out_data, out_valid, out_last
  );
endinterface

// File: rtl/sram_stream_reader.sv
// Burst read sequencer: issues sequential SRAM addresses and streams the words out with a last flag.
// Latency: first out_valid 3 cycles after the start cycle; 1 word/cycle sustained with out_ready high.
// Backpressure: issue is throttled so FIFO + in-flight never exceeds FIFO_DEPTH. STREAM_READER_PERF_EN adds stall_cycles.
module sram_stream_reader #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sram_stream_reader_if.master bus
`ifdef STREAM_READER_PERF_EN
  ,
  output logic [15:0]          stall_cycles
`endif
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int LW = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t                state;
  logic                  busy_q;
  logic                  done_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] rd_addr_q;
  logic [LW-1:0]         len_q;
  logic [LW-1:0]         issue_cnt;
  logic [LW-1:0]         beat_cnt;
  logic                  inflight;

  // Skid FIFO: each entry carries {last, data}.
  logic [DATA_WIDTH:0]   mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         fifo_cnt;

  logic                  fifo_empty;
  logic                  pop;
  logic                  push;
  logic                  push_last;
  logic [DATA_WIDTH:0]   head;
  logic                  head_last;
  logic [CW:0]           occ_after_pop;
  logic                  issue;
  logic                  final_issue;
  logic                  finish;
  logic                  accept;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign fifo_empty = (fifo_cnt == '0);
  assign pop        = !fifo_empty && bus.out_ready;
  assign push       = inflight;
  assign head       = mem[rd_ptr];
  assign head_last  = head[DATA_WIDTH];
  assign push_last  = (beat_cnt == len_q - LW'(1));
  assign accept     = (state == IDLE) && bus.start;

  // Occupancy counts the word still coming back from the SRAM, so a full FIFO can never be overrun.
  assign occ_after_pop = {1'b0, fifo_cnt} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, pop};
  assign issue         = (state == READ) && (issue_cnt < len_q) && (occ_after_pop < (CW + 1)'(FIFO_DEPTH));
  assign final_issue   = issue && ((issue_cnt + LW'(1)) == len_q);
  assign finish        = pop && head_last;

  // Burst sequencing: command latch, address issue and completion with registered busy/done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      addr_q    <= '0;
      rd_addr_q <= '0;
      len_q     <= '0;
      issue_cnt <= '0;
      inflight  <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      inflight <= issue;
      if (issue) begin
        rd_addr_q <= addr_q;
        addr_q    <= addr_q + ADDR_WIDTH'(1);
        issue_cnt <= issue_cnt + LW'(1);
      end
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (bus.length != '0) begin
              state     <= READ;
              busy_q    <= 1'b1;
              addr_q    <= bus.base_addr;
              len_q     <= bus.length;
              issue_cnt <= '0;
            end else begin
              // Zero-length burst completes immediately without touching the SRAM.
              done_q <= 1'b1;
            end
          end
        end
        READ: begin
          if (finish) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else if (final_issue) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (finish) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Skid FIFO: capture the SRAM word one cycle after issue and tag the final beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      beat_cnt <= '0;
    end else begin
      if (accept) beat_cnt <= '0;
      if (push) begin
        mem[wr_ptr] <= {push_last, bus.sram_read_data};
        wr_ptr      <= ptr_inc(wr_ptr);
        beat_cnt    <= beat_cnt + LW'(1);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

`ifdef STREAM_READER_PERF_EN
  // Saturating count of backpressured cycles in the current burst; survives done until the next start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
    end else if (accept) begin
      stall_cycles <= '0;
    end else if (busy_q && !fifo_empty && !bus.out_ready && (stall_cycles != 16'hFFFF)) begin
      stall_cycles <= stall_cycles + 16'd1;
    end
  end
`endif

  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.sram_read_addr = rd_addr_q;
  assign bus.out_valid      = !fifo_empty;
  assign bus.out_data       = head[DATA_WIDTH-1:0];
  assign bus.out_last       = !fifo_empty && head_last;

endmodule

// File: tb/tb_sram_stream_reader.sv
// Directed bench for sram_stream_reader with a combinational-view SRAM model preloaded mem[i]=i*3.
// Latency: inputs driven 1ns after the rising edge, outputs sampled on the falling edge.
// Backpressure: out_ready is held high or toggled per directed step.
module tb_sram_stream_reader;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   stall_seen;
  int   got;
  logic overflow_seen;

  logic [15:0] mem [256];
  logic [16:0] got_q [$];
  logic [7:0]  addr_log [$];
  logic [7:0]  last_addr;
  logic        prev_stall;
  logic [15:0] prev_data;
  logic        prev_last;

  sram_stream_reader_if #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) bus ();

`ifdef STREAM_READER_PERF_EN
  logic [15:0] stall_cycles;
`endif

  sram_stream_reader #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .FIFO_DEPTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef STREAM_READER_PERF_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  // SRAM read data follows the registered read address, one cycle after the issue decision.
  assign bus.sram_read_data = mem[bus.sram_read_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_word(input string tag, input int idx, input logic [16:0] exp);
    logic [16:0] obs;
    obs = (idx < got_q.size()) ? got_q[idx] : 17'bx;
    check(tag, 32'(obs), 32'(exp));
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic wait_done(input int budget, output int seen);
    seen = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.done) begin
        seen = 1;
        break;
      end
    end
  endtask

  // Stream monitor: handshake log, stall stability, address log and FIFO bound.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", 32'(bus.out_valid), 32'd1);
        check("hold_data", 32'(bus.out_data), 32'(prev_data));
        check("hold_last", 32'(bus.out_last), 32'(prev_last));
      end
      if (bus.out_valid && bus.out_ready) got_q.push_back({bus.out_last, bus.out_data});
      if (bus.out_valid && !bus.out_ready) stall_seen++;
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
      prev_last  = bus.out_last;
      if (bus.sram_read_addr != last_addr) begin
        addr_log.push_back(bus.sram_read_addr);
        last_addr = bus.sram_read_addr;
      end
      if (dut.fifo_cnt > 2) overflow_seen = 1'b1;
    end
  end

  initial begin
    logic [15:0] t1_exp [4];
    logic [7:0]  t2_addr [4];
    logic [15:0] t2_data [4];
    t1_exp  = '{16'h0030, 16'h0033, 16'h0036, 16'h0039};
    t2_addr = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    t2_data = '{16'h02FA, 16'h02FD, 16'h0000, 16'h0003};

    checks = 0; errors = 0; stall_seen = 0; overflow_seen = 1'b0;
    last_addr = 8'h00; prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 16'(i * 3);
    rst_n = 1'b0;
    bus.start = 1'b0; bus.base_addr = '0; bus.length = '0; bus.out_ready = 1'b0;

    // Reset state.
    repeat (3) @(posedge clk);
    smp();
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_last", 32'(bus.out_last), 32'd0);
    check("rst_addr", 32'(bus.sram_read_addr), 32'd0);
    check("rst_data", 32'(bus.out_data), 32'd0);
    nxt(); rst_n = 1'b1;
    smp();
    check("idle_busy", 32'(bus.busy), 32'd0);

    // Burst base 0x10 length 4, ready high: cycle-exact latency.
    got_q.delete();
    nxt(); bus.start = 1'b1; bus.base_addr = 8'h10; bus.length = 9'd4; bus.out_ready = 1'b1;
    smp(); check("t1_busy_c0", 32'(bus.busy), 32'd0);
    nxt(); bus.start = 1'b0;
    smp(); check("t1_busy_c1", 32'(bus.busy), 32'd1);
    check("t1_valid_c1", 32'(bus.out_valid), 32'd0);
    nxt();
    smp(); check("t1_valid_c2", 32'(bus.out_valid), 32'd0);
    check("t1_addr_c2", 32'(bus.sram_read_addr), 32'h10);
    for (int k = 0; k < 4; k++) begin
      nxt(); smp();
      check("t1_valid", 32'(bus.out_valid), 32'd1);
      check("t1_data", 32'(bus.out_data), 32'(t1_exp[k]));
      check("t1_last", 32'(bus.out_last), 32'(k == 3));
    end
    nxt(); smp();
    check("t1_done", 32'(bus.done), 32'd1);
    check("t1_busy_end", 32'(bus.busy), 32'd0);
    check("t1_valid_end", 32'(bus.out_valid), 32'd0);
    nxt(); smp();
    check("t1_done_pulse", 32'(bus.done), 32'd0);

    // Address wrap: base 0xFE length 4.
    got_q.delete(); addr_log.delete();
    nxt(); bus.start = 1'b1; bus.base_addr = 8'hFE; bus.length = 9'd4;
    nxt(); bus.start = 1'b0;
    wait_done(30, got);
    check("t2_done_seen", 32'(got), 32'd1);
    check("t2_addr_cnt", 32'(addr_log.size()), 32'd4);
    for (int k = 0; k < 4; k++) begin
      check("t2_addr", 32'((k < addr_log.size()) ? addr_log[k] : 8'bx), 32'(t2_addr[k]));
      check_word("t2_word", k, {1'(k == 3), t2_data[k]});
    end
    check("t2_word_cnt", 32'(got_q.size()), 32'd4);

    // Length 6 with ready pattern 1,0,0 repeating from the start cycle.
    got_q.delete(); stall_seen = 0; got = 0;
    nxt(); bus.start = 1'b1; bus.base_addr = 8'h20; bus.length = 9'd6; bus.out_ready = 1'b1;
    for (int k = 1; k < 80; k++) begin
      nxt(); bus.start = 1'b0; bus.out_ready = ((k % 3) == 0);
      smp();
      if (bus.done) begin
        got = 1;
        break;
      end
    end
    bus.out_ready = 1'b1;
    check("t3_done_seen", 32'(got), 32'd1);
    check("t3_word_cnt", 32'(got_q.size()), 32'd6);
    for (int k = 0; k < 6; k++) check_word("t3_word", k, {1'(k == 5), 16'(16'h60 + 3 * k)});
    check("t3_stalls_seen", 32'(stall_seen != 0), 32'd1);
`ifdef STREAM_READER_PERF_EN
    check("t3_stall_cnt", 32'(stall_cycles), 32'(stall_seen));
    nxt(); smp();
    check("t3_stall_hold", 32'(stall_cycles), 32'(stall_seen));
`endif

    // Zero-length burst.
    got_q.delete();
    nxt(); bus.start = 1'b1; bus.base_addr = 8'h33; bus.length = 9'd0;
    smp(); check("t4_done_c0", 32'(bus.done), 32'd0);
    nxt(); bus.start = 1'b0;
    smp(); check("t4_done_c1", 32'(bus.done), 32'd1);
    check("t4_busy_c1", 32'(bus.busy), 32'd0);
    check("t4_valid_c1", 32'(bus.out_valid), 32'd0);
    nxt(); smp();
    check("t4_done_c2", 32'(bus.done), 32'd0);
    repeat (3) nxt();
    smp();
    check("t4_no_words", 32'(got_q.size()), 32'd0);
    check("t4_busy_end", 32'(bus.busy), 32'd0);
`ifdef STREAM_READER_PERF_EN
    check("t4_stall_clr", 32'(stall_cycles), 32'd0);
`endif

    // Start re-pulsed mid-burst is ignored.
    got_q.delete();
    nxt(); bus.start = 1'b1; bus.base_addr = 8'h80; bus.length = 9'd8;
    nxt(); bus.start = 1'b0;
    nxt();
    nxt(); bus.start = 1'b1; bus.base_addr = 8'h00; bus.length = 9'd3;
    nxt(); bus.start = 1'b0;
    wait_done(40, got);
    check("t5_done_seen", 32'(got), 32'd1);
    repeat (6) nxt();
    smp();
    check("t5_word_cnt", 32'(got_q.size()), 32'd8);
    for (int k = 0; k < 8; k++) check_word("t5_word", k, {1'(k == 7), 16'(16'h180 + 3 * k)});
    check("t5_busy_end", 32'(bus.busy), 32'd0);

    // Reset after 2 of 8 words, then a fresh short burst.
    got_q.delete(); got = 0;
    nxt(); bus.start = 1'b1; bus.base_addr = 8'h90; bus.length = 9'd8;
    nxt(); bus.start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      smp();
      if (got_q.size() >= 2) begin
        got = 1;
        break;
      end
    end
    check("t6_two_words", 32'(got), 32'd1);
    nxt(); rst_n = 1'b0;
    #1;
    check("t6_rst_busy", 32'(bus.busy), 32'd0);
    check("t6_rst_done", 32'(bus.done), 32'd0);
    check("t6_rst_valid", 32'(bus.out_valid), 32'd0);
    check("t6_rst_last", 32'(bus.out_last), 32'd0);
    check("t6_rst_addr", 32'(bus.sram_read_addr), 32'd0);
    check("t6_rst_data", 32'(bus.out_data), 32'd0);
    nxt(); nxt(); rst_n = 1'b1;
    got_q.delete();
    nxt(); bus.start = 1'b1; bus.base_addr = 8'h40; bus.length = 9'd2;
    nxt(); bus.start = 1'b0;
    wait_done(30, got);
    check("t6_done_seen", 32'(got), 32'd1);
    repeat (3) nxt();
    smp();
    check("t6_word_cnt", 32'(got_q.size()), 32'd2);
    check_word("t6_word0", 0, {1'b0, 16'h00C0});
    check_word("t6_word1", 1, {1'b1, 16'h00C3});

    check("fifo_bound", 32'(overflow_seen), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
